// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-qualified h/v counters, programmable
// sync polarity, a linear framebuffer address counter (no multiplier) and a
// LAT-deep delay line that lines sync/blank up with returned pixel data.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int ADDR_W   = 19,
  parameter int LAT      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  output logic [10:0]       x,
  output logic [10:0]       y,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              line_start,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_LAST = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_LAST = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [10:0]       h_q;
  logic [10:0]       v_q;
  logic [ADDR_W-1:0] addr_q;
  logic              h_wrap;
  logic              v_wrap;
  logic              active;
  logic              hs_raw;
  logic              vs_raw;
  logic [2:0]        raw_vec;
  logic [2:0]        dly_out;

  assign h_wrap = (h_q == H_LAST);
  assign v_wrap = (v_q == V_LAST);
  assign active = (h_q < H_ACT) && (v_q < V_ACT);

  // Raster counters: h runs every qualified pixel, v steps on the h wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else if (pix_en) begin
      if (h_wrap) begin
        h_q <= '0;
        v_q <= v_wrap ? '0 : v_q + 11'd1;
      end else begin
        h_q <= h_q + 11'd1;
      end
    end
  end

  // Linear address: steps only out of visible pixels so it stays contiguous
  // across lines, and restarts at the frame wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else if (pix_en) begin
      if (h_wrap && v_wrap) begin
        addr_q <= '0;
      end else if (active) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

  assign hs_raw  = (h_q >= HS_BEG && h_q <= HS_LAST) ? HS_POL : ~HS_POL;
  assign vs_raw  = (v_q >= VS_BEG && v_q <= VS_LAST) ? VS_POL : ~VS_POL;
  assign raw_vec = {hs_raw, active, vs_raw};

  generate
    if (LAT == 0) begin : g_direct
      assign dly_out = raw_vec;
    end else begin : g_pipe
      localparam logic [2:0] RST_VEC = {~HS_POL, 1'b0, ~VS_POL};
      logic [2:0] stage [LAT];

      // Delay line for {hsync, de, vsync}, shifting once per qualified pixel.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < LAT; i++) stage[i] <= RST_VEC;
        end else if (pix_en) begin
          stage[0] <= raw_vec;
          for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
        end
      end

      assign dly_out = stage[LAT-1];
    end
  endgenerate

  assign {hsync, de, vsync} = dly_out;
  assign x          = h_q;
  assign y          = v_q;
  assign addr       = addr_q;
  assign addr_valid = active;

  // Gated by rst_n so a held reset never shows a start pulse.
  assign line_start  = rst_n & pix_en & (h_q == 11'd0);
  assign frame_start = line_start & (v_q == 11'd0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four configurations share clock, reset and
// pix_en; expected values come from a pixel-index model (count of qualified
// advances since reset, turned into position and decoded with arithmetic).
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic pix_en;
  int   checks = 0;
  int   errors = 0;
  int   n = 0;

  typedef struct packed {
    int ha; int hfp; int hsw; int hbp;
    int va; int vfp; int vsw; int vbp;
    int lat; bit hpol; bit vpol;
  } cfg_t;

  localparam cfg_t C_DEF   = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b0, 1'b0};
  localparam cfg_t C_LAT2  = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b1, 1'b1};
  localparam cfg_t C_MID   = '{40, 4, 6, 4, 12, 2, 2, 3, 0, 1'b0, 1'b0};
  localparam cfg_t C_SMALL = '{4, 1, 1, 1, 3, 1, 1, 1, 1, 1'b0, 1'b0};

  logic [10:0] d_x, d_y, l_x, l_y, m_x, m_y, s_x, s_y;
  logic [18:0] d_addr, l_addr;
  logic [8:0]  m_addr;
  logic [3:0]  s_addr;
  logic d_av, d_hs, d_vs, d_de, d_ls, d_fs;
  logic l_av, l_hs, l_vs, l_de, l_ls, l_fs;
  logic m_av, m_hs, m_vs, m_de, m_ls, m_fs;
  logic s_av, s_hs, s_vs, s_de, s_ls, s_fs;

  vga_timing_gen u_def (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x(d_x), .y(d_y), .addr(d_addr),
    .addr_valid(d_av), .hsync(d_hs), .vsync(d_vs), .de(d_de),
    .line_start(d_ls), .frame_start(d_fs));

  vga_timing_gen #(.LAT(2), .HS_POL(1'b1), .VS_POL(1'b1)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x(l_x), .y(l_y), .addr(l_addr),
    .addr_valid(l_av), .hsync(l_hs), .vsync(l_vs), .de(l_de),
    .line_start(l_ls), .frame_start(l_fs));

  vga_timing_gen #(.H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(4),
                   .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
                   .ADDR_W(9), .LAT(0)) u_mid (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x(m_x), .y(m_y), .addr(m_addr),
    .addr_valid(m_av), .hsync(m_hs), .vsync(m_vs), .de(m_de),
    .line_start(m_ls), .frame_start(m_fs));

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
                   .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .ADDR_W(4), .LAT(1)) u_small (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x(s_x), .y(s_y), .addr(s_addr),
    .addr_valid(s_av), .hsync(s_hs), .vsync(s_vs), .de(s_de),
    .line_start(s_ls), .frame_start(s_fs));

  // Reference pixel index: number of qualified advances since reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else if (pix_en) n <= n + 1;
  end

  int ex, ey, ea;
  bit eav, ehs, evs, ede, els, efs;

  function automatic void model(input cfg_t c, input int cnt,
                                output int ox, output int oy, output int oa,
                                output bit oav, output bit ohs, output bit ovs,
                                output bit ode);
    int ht, vt, p, dx, dy;
    ht  = c.ha + c.hfp + c.hsw + c.hbp;
    vt  = c.va + c.vfp + c.vsw + c.vbp;
    p   = cnt % (ht * vt);
    ox  = p % ht;
    oy  = p / ht;
    oav = (ox < c.ha) && (oy < c.va);
    oa  = oy * c.ha + ox;
    if (cnt < c.lat) begin
      ohs = ~c.hpol; ovs = ~c.vpol; ode = 1'b0;
    end else begin
      p   = (cnt - c.lat) % (ht * vt);
      dx  = p % ht;
      dy  = p / ht;
      ohs = (dx >= c.ha + c.hfp && dx < c.ha + c.hfp + c.hsw) ? c.hpol : ~c.hpol;
      ovs = (dy >= c.va + c.vfp && dy < c.va + c.vfp + c.vsw) ? c.vpol : ~c.vpol;
      ode = (dx < c.ha) && (dy < c.va);
    end
  endfunction

  task automatic test_reset();
    rst_n  = 1'b0;
    pix_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks += 13;
    if (l_x !== 11'd0)    begin errors++; $display("FAIL rst_x got %0d exp 0", l_x); end
    if (l_y !== 11'd0)    begin errors++; $display("FAIL rst_y got %0d exp 0", l_y); end
    if (l_addr !== 19'd0) begin errors++; $display("FAIL rst_addr got %0d exp 0", l_addr); end
    if (l_hs !== 1'b0)    begin errors++; $display("FAIL rst_hs_pol1 got %b exp 0", l_hs); end
    if (l_vs !== 1'b0)    begin errors++; $display("FAIL rst_vs_pol1 got %b exp 0", l_vs); end
    if (l_de !== 1'b0)    begin errors++; $display("FAIL rst_de got %b exp 0", l_de); end
    if (l_av !== 1'b1)    begin errors++; $display("FAIL rst_av got %b exp 1", l_av); end
    if (l_ls !== 1'b0)    begin errors++; $display("FAIL rst_ls got %b exp 0", l_ls); end
    if (l_fs !== 1'b0)    begin errors++; $display("FAIL rst_fs got %b exp 0", l_fs); end
    if (s_hs !== 1'b1)    begin errors++; $display("FAIL rst_hs_pol0 got %b exp 1", s_hs); end
    if (s_vs !== 1'b1)    begin errors++; $display("FAIL rst_vs_pol0 got %b exp 1", s_vs); end
    if (s_de !== 1'b0)    begin errors++; $display("FAIL rst_small_de got %b exp 0", s_de); end
    if (d_de !== 1'b0)    begin errors++; $display("FAIL rst_def_de got %b exp 0", d_de); end
    @(negedge clk);
    pix_en = 1'b0;
    rst_n  = 1'b1;
  endtask

  // Default timing with pix_en every 2nd clk, covering two full lines.
  task automatic test_default_lines();
    int since_ls = -1;
    int hs_cnt   = -1;
    int av_cnt   = -1;
    bit prev_lhs = 1'b0, prev_lav = 1'b1, prev_lde = 1'b0;
    for (int cyc = 0; cyc < 3400; cyc++) begin
      @(negedge clk);
      pix_en = (cyc % 2 == 0);
      #1;
      model(C_DEF, n, ex, ey, ea, eav, ehs, evs, ede);
      els = rst_n && pix_en && ex == 0;
      efs = els && ey == 0;
      checks += 8;
      if (d_x !== 11'(ex))   begin errors++; $display("FAIL def_x n=%0d got %0d exp %0d", n, d_x, ex); end
      if (d_y !== 11'(ey))   begin errors++; $display("FAIL def_y n=%0d got %0d exp %0d", n, d_y, ey); end
      if (d_av !== eav)      begin errors++; $display("FAIL def_av n=%0d got %b exp %b", n, d_av, eav); end
      if (d_hs !== ehs)      begin errors++; $display("FAIL def_hs n=%0d got %b exp %b", n, d_hs, ehs); end
      if (d_vs !== evs)      begin errors++; $display("FAIL def_vs n=%0d got %b exp %b", n, d_vs, evs); end
      if (d_de !== ede)      begin errors++; $display("FAIL def_de n=%0d got %b exp %b", n, d_de, ede); end
      if (d_ls !== els)      begin errors++; $display("FAIL def_ls n=%0d got %b exp %b", n, d_ls, els); end
      if (d_fs !== efs)      begin errors++; $display("FAIL def_fs n=%0d got %b exp %b", n, d_fs, efs); end
      if (eav) begin
        checks++;
        if (d_addr !== 19'(ea)) begin errors++; $display("FAIL def_addr n=%0d got %0d exp %0d", n, d_addr, ea); end
      end
      if (ex == 639 && ey == 0) begin
        checks++;
        if (d_addr !== 19'd639) begin errors++; $display("FAIL addr_639_0 got %0d exp 639", d_addr); end
      end
      if (ex == 0 && ey == 1) begin
        checks++;
        if (d_addr !== 19'd640) begin errors++; $display("FAIL addr_0_1 got %0d exp 640", d_addr); end
      end
      if (d_ls) begin
        if (since_ls >= 0) begin
          checks++;
          if (since_ls !== 800) begin errors++; $display("FAIL line_period got %0d exp 800", since_ls); end
        end
        since_ls = 0;
      end
      if (pix_en && since_ls >= 0) since_ls++;

      model(C_LAT2, n, ex, ey, ea, eav, ehs, evs, ede);
      els = rst_n && pix_en && ex == 0;
      efs = els && ey == 0;
      checks += 8;
      if (l_x !== 11'(ex))   begin errors++; $display("FAIL lat2_x n=%0d got %0d exp %0d", n, l_x, ex); end
      if (l_y !== 11'(ey))   begin errors++; $display("FAIL lat2_y n=%0d got %0d exp %0d", n, l_y, ey); end
      if (l_av !== eav)      begin errors++; $display("FAIL lat2_av n=%0d got %b exp %b", n, l_av, eav); end
      if (l_hs !== ehs)      begin errors++; $display("FAIL lat2_hs n=%0d got %b exp %b", n, l_hs, ehs); end
      if (l_vs !== evs)      begin errors++; $display("FAIL lat2_vs n=%0d got %b exp %b", n, l_vs, evs); end
      if (l_de !== ede)      begin errors++; $display("FAIL lat2_de n=%0d got %b exp %b", n, l_de, ede); end
      if (l_ls !== els)      begin errors++; $display("FAIL lat2_ls n=%0d got %b exp %b", n, l_ls, els); end
      if (l_fs !== efs)      begin errors++; $display("FAIL lat2_fs n=%0d got %b exp %b", n, l_fs, efs); end
      if (eav) begin
        checks++;
        if (l_addr !== 19'(ea)) begin errors++; $display("FAIL lat2_addr n=%0d got %0d exp %0d", n, l_addr, ea); end
      end
      if (l_hs && !prev_lhs) begin
        checks++;
        if (l_x !== 11'd658) begin errors++; $display("FAIL lat2_hs_start_x got %0d exp 658", l_x); end
        hs_cnt = 0;
      end
      if (!l_hs && prev_lhs && hs_cnt >= 0) begin
        checks++;
        if (hs_cnt !== 96) begin errors++; $display("FAIL lat2_hs_width got %0d exp 96", hs_cnt); end
        hs_cnt = -1;
      end
      if (hs_cnt >= 0 && l_hs && pix_en) hs_cnt++;
      if (l_av && !prev_lav) av_cnt = 0;
      if (l_de && !prev_lde && av_cnt >= 0) begin
        checks++;
        if (av_cnt !== 2) begin errors++; $display("FAIL lat2_de_delay got %0d exp 2", av_cnt); end
        av_cnt = -1;
      end
      if (av_cnt >= 0 && pix_en) av_cnt++;
      prev_lhs = l_hs;
      prev_lav = l_av;
      prev_lde = l_de;
    end
  endtask

  // pix_en held low for 37 clks mid-line: everything must freeze.
  task automatic test_hold();
    for (int cyc = 0; cyc < 37; cyc++) begin
      @(negedge clk);
      pix_en = 1'b0;
      #1;
      model(C_DEF, n, ex, ey, ea, eav, ehs, evs, ede);
      checks += 8;
      if (d_x !== 11'(ex))    begin errors++; $display("FAIL hold_x got %0d exp %0d", d_x, ex); end
      if (d_y !== 11'(ey))    begin errors++; $display("FAIL hold_y got %0d exp %0d", d_y, ey); end
      if (d_addr !== 19'(ea)) begin errors++; $display("FAIL hold_addr got %0d exp %0d", d_addr, ea); end
      if (d_hs !== ehs)       begin errors++; $display("FAIL hold_hs got %b exp %b", d_hs, ehs); end
      if (d_vs !== evs)       begin errors++; $display("FAIL hold_vs got %b exp %b", d_vs, evs); end
      if (d_de !== ede)       begin errors++; $display("FAIL hold_de got %b exp %b", d_de, ede); end
      if (d_ls !== 1'b0)      begin errors++; $display("FAIL hold_ls got %b exp 0", d_ls); end
      if (l_fs !== 1'b0)      begin errors++; $display("FAIL hold_fs got %b exp 0", l_fs); end
    end
  endtask

  // Reduced raster with random pix_en across several whole frames.
  task automatic test_mid_frames();
    int since_fs = -1;
    int de_cnt   = 0;
    bit prev_vs  = 1'b1;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clk);
      pix_en = ($urandom_range(3, 0) != 0);
      #1;
      model(C_MID, n, ex, ey, ea, eav, ehs, evs, ede);
      els = rst_n && pix_en && ex == 0;
      efs = els && ey == 0;
      checks += 8;
      if (m_x !== 11'(ex))   begin errors++; $display("FAIL mid_x n=%0d got %0d exp %0d", n, m_x, ex); end
      if (m_y !== 11'(ey))   begin errors++; $display("FAIL mid_y n=%0d got %0d exp %0d", n, m_y, ey); end
      if (m_av !== eav)      begin errors++; $display("FAIL mid_av n=%0d got %b exp %b", n, m_av, eav); end
      if (m_hs !== ehs)      begin errors++; $display("FAIL mid_hs n=%0d got %b exp %b", n, m_hs, ehs); end
      if (m_vs !== evs)      begin errors++; $display("FAIL mid_vs n=%0d got %b exp %b", n, m_vs, evs); end
      if (m_de !== ede)      begin errors++; $display("FAIL mid_de n=%0d got %b exp %b", n, m_de, ede); end
      if (m_ls !== els)      begin errors++; $display("FAIL mid_ls n=%0d got %b exp %b", n, m_ls, els); end
      if (m_fs !== efs)      begin errors++; $display("FAIL mid_fs n=%0d got %b exp %b", n, m_fs, efs); end
      if (eav) begin
        checks++;
        if (m_addr !== 9'(ea)) begin errors++; $display("FAIL mid_addr n=%0d got %0d exp %0d", n, m_addr, ea); end
      end
      if (ex == 39 && ey == 11) begin
        checks++;
        if (m_addr !== 9'd479) begin errors++; $display("FAIL mid_addr_last got %0d exp 479", m_addr); end
      end
      if (!m_vs && prev_vs) begin
        checks += 2;
        if (m_x !== 11'd0)  begin errors++; $display("FAIL mid_vs_start_x got %0d exp 0", m_x); end
        if (m_y !== 11'd14) begin errors++; $display("FAIL mid_vs_start_y got %0d exp 14", m_y); end
      end
      prev_vs = m_vs;
      if (m_fs) begin
        if (since_fs >= 0) begin
          checks += 2;
          if (since_fs !== 1026) begin errors++; $display("FAIL mid_frame_period got %0d exp 1026", since_fs); end
          if (de_cnt !== 480)    begin errors++; $display("FAIL mid_de_per_frame got %0d exp 480", de_cnt); end
        end
        since_fs = 0;
        de_cnt   = 0;
      end
      if (pix_en && since_fs >= 0) begin
        since_fs++;
        if (m_de) de_cnt++;
      end
    end
  endtask

  // Tiny raster: exact frame sequence, then async reset mid-clk at (5,3).
  task automatic test_small_frame_and_reset();
    bit found = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      model(C_SMALL, n, ex, ey, ea, eav, ehs, evs, ede);
      found  = (cyc >= 100) && ex == 5 && ey == 3;
      pix_en = found ? 1'b0 : 1'($urandom_range(1, 0));
      #1;
      els = rst_n && pix_en && ex == 0;
      efs = els && ey == 0;
      checks += 8;
      if (s_x !== 11'(ex))   begin errors++; $display("FAIL small_x n=%0d got %0d exp %0d", n, s_x, ex); end
      if (s_y !== 11'(ey))   begin errors++; $display("FAIL small_y n=%0d got %0d exp %0d", n, s_y, ey); end
      if (s_av !== eav)      begin errors++; $display("FAIL small_av n=%0d got %b exp %b", n, s_av, eav); end
      if (s_hs !== ehs)      begin errors++; $display("FAIL small_hs n=%0d got %b exp %b", n, s_hs, ehs); end
      if (s_vs !== evs)      begin errors++; $display("FAIL small_vs n=%0d got %b exp %b", n, s_vs, evs); end
      if (s_de !== ede)      begin errors++; $display("FAIL small_de n=%0d got %b exp %b", n, s_de, ede); end
      if (s_ls !== els)      begin errors++; $display("FAIL small_ls n=%0d got %b exp %b", n, s_ls, els); end
      if (s_fs !== efs)      begin errors++; $display("FAIL small_fs n=%0d got %b exp %b", n, s_fs, efs); end
      if (eav) begin
        checks++;
        if (s_addr !== 4'(ea)) begin errors++; $display("FAIL small_addr n=%0d got %0d exp %0d", n, s_addr, ea); end
      end
      if (found) break;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL small_reach_5_3 got not-reached exp reached");
    end
    @(posedge clk);
    #3;
    rst_n  = 1'b0;
    pix_en = 1'b1;
    #1;
    checks += 9;
    if (s_x !== 11'd0)   begin errors++; $display("FAIL async_rst_x got %0d exp 0", s_x); end
    if (s_y !== 11'd0)   begin errors++; $display("FAIL async_rst_y got %0d exp 0", s_y); end
    if (s_addr !== 4'd0) begin errors++; $display("FAIL async_rst_addr got %0d exp 0", s_addr); end
    if (s_hs !== 1'b1)   begin errors++; $display("FAIL async_rst_hs got %b exp 1", s_hs); end
    if (s_vs !== 1'b1)   begin errors++; $display("FAIL async_rst_vs got %b exp 1", s_vs); end
    if (s_de !== 1'b0)   begin errors++; $display("FAIL async_rst_de got %b exp 0", s_de); end
    if (s_av !== 1'b1)   begin errors++; $display("FAIL async_rst_av got %b exp 1", s_av); end
    if (s_ls !== 1'b0)   begin errors++; $display("FAIL async_rst_ls got %b exp 0", s_ls); end
    if (s_fs !== 1'b0)   begin errors++; $display("FAIL async_rst_fs got %b exp 0", s_fs); end
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    pix_en = 1'b1;
    #1;
    checks += 2;
    if (s_fs !== 1'b1) begin errors++; $display("FAIL post_rst_fs got %b exp 1", s_fs); end
    if (s_x !== 11'd0) begin errors++; $display("FAIL post_rst_x got %0d exp 0", s_x); end
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      pix_en = 1'($urandom_range(1, 0));
      #1;
      model(C_SMALL, n, ex, ey, ea, eav, ehs, evs, ede);
      efs = rst_n && pix_en && ex == 0 && ey == 0;
      checks += 4;
      if (s_x !== 11'(ex)) begin errors++; $display("FAIL post_rst_x n=%0d got %0d exp %0d", n, s_x, ex); end
      if (s_y !== 11'(ey)) begin errors++; $display("FAIL post_rst_y n=%0d got %0d exp %0d", n, s_y, ey); end
      if (s_hs !== ehs)    begin errors++; $display("FAIL post_rst_hs n=%0d got %b exp %b", n, s_hs, ehs); end
      if (s_fs !== efs)    begin errors++; $display("FAIL post_rst_fs n=%0d got %b exp %b", n, s_fs, efs); end
    end
  endtask

  initial begin
    test_reset();
    test_default_lines();
    test_hold();
    test_mid_frames();
    test_small_frame_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
